// File: rtl/ras_ctrl_pkg.sv
// Shared definitions for the return-address stack: truth macros, default depth, slot encodings.
`ifndef RAS_CTRL_TRUTH_DEFINED
`define RAS_CTRL_TRUTH_DEFINED
`define TRUE  1'b1
`define FALSE 1'b0
`endif

package ras_ctrl_pkg;

  localparam int RAS_DEPTH = 8;

  localparam logic SLOT_1 = 1'b0;
  localparam logic SLOT_2 = 1'b1;

  typedef enum logic [1:0] {
    RAS_NOP  = 2'd0,
    RAS_PUSH = 2'd1,
    RAS_POP  = 2'd2
  } ras_op_e;

  // Return address of a BSR sitting in the given slot of the bundle starting at pc_1.
  function automatic logic [63:0] slot_ret_addr(input logic [63:0] pc_1, input logic slot);
    if (slot == SLOT_2) begin
      slot_ret_addr = pc_1 + 64'd8;
    end else begin
      slot_ret_addr = pc_1 + 64'd4;
    end
  endfunction

endpackage

// File: rtl/ras_storage.sv
// DEPTH x 64 return-address register file: one write port, one combinational read port.
// With RAS_TOP_REPAIR_EN a second write port repairs the top entry on recovery.
module ras_storage
  import ras_ctrl_pkg::*;
#(
  parameter int DEPTH = RAS_DEPTH,
  parameter int PTR_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_idx,
  input  logic [63:0]      wr_data,
`ifdef RAS_TOP_REPAIR_EN
  input  logic             rep_en,
  input  logic [PTR_W-1:0] rep_idx,
  input  logic [63:0]      rep_data,
`endif
  input  logic [PTR_W-1:0] rd_idx,
  output logic [63:0]      rd_data
);

  logic [63:0] mem_r [DEPTH];

  // Entry storage; push and repair writes are mutually exclusive by construction.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 64'd0;
      end
    end else if (wr_en) begin
      mem_r[wr_idx] <= wr_data;
    end
`ifdef RAS_TOP_REPAIR_EN
    else if (rep_en) begin
      mem_r[rep_idx] <= rep_data;
    end
`endif
  end

  assign rd_data = mem_r[rd_idx];

endmodule

// File: rtl/ras_ctrl.sv
// Return-address-stack controller: slot selection, push/pop, pointer checkpoint and recovery.
// Optional top-entry repair on recovery is enabled by RAS_TOP_REPAIR_EN.
module ras_ctrl
  import ras_ctrl_pkg::*;
#(
  parameter int DEPTH = RAS_DEPTH,
  parameter int PTR_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             if_valid,
  input  logic             if_stall,
  input  logic [63:0]      pc_1,
  input  logic             bsr_branch_1,
  input  logic             bsr_branch_2,
  input  logic             ret_branch_1,
  input  logic             ret_branch_2,
  input  logic             uncond_branch_1,
  input  logic             uncond_branch_2,
  input  logic             recover_en,
  input  logic [PTR_W-1:0] recover_tos,
  input  logic [PTR_W:0]   recover_cnt,
`ifdef RAS_TOP_REPAIR_EN
  input  logic [63:0]      recover_top,
  output logic [63:0]      ckpt_top,
`endif
  output logic             slot2_kill,
  output logic             ret_pred_valid,
  output logic             ret_pred_slot,
  output logic [63:0]      ret_pred_pc,
  output logic [PTR_W-1:0] ckpt_tos,
  output logic [PTR_W:0]   ckpt_cnt
);

  localparam logic [PTR_W-1:0] TOS_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W:0]   CNT_ONE  = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W:0]   CNT_ZERO = {(PTR_W+1){1'b0}};
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] tos_r, tos_nxt_s;
  logic [PTR_W:0]   cnt_r, cnt_nxt_s;
  logic             sel_slot_s, sel_bsr_s, sel_ret_s;
  ras_op_e          op_s;
  logic             active_s, wr_en_s, pred_hit_s;
  logic [63:0]      top_data_s;

  assign active_s = if_valid & ~if_stall & ~recover_en;

  // A slot-1 unconditional transfer hides slot 2, so only one slot is ever examined.
  always_comb begin
    sel_slot_s = SLOT_2;
    sel_bsr_s  = `FALSE;
    sel_ret_s  = `FALSE;
    op_s       = RAS_NOP;
    if (uncond_branch_1) begin
      sel_slot_s = SLOT_1;
      sel_bsr_s  = bsr_branch_1;
      sel_ret_s  = ret_branch_1;
    end else begin
      sel_slot_s = SLOT_2;
      sel_bsr_s  = bsr_branch_2;
      sel_ret_s  = ret_branch_2;
    end
    if (sel_bsr_s) begin
      op_s = RAS_PUSH;
    end else if (sel_ret_s) begin
      op_s = RAS_POP;
    end else begin
      op_s = RAS_NOP;
    end
  end

  // Zero-latency prediction outputs, qualified by if_valid.
  always_comb begin
    pred_hit_s     = if_valid & (op_s == RAS_POP) & (cnt_r != CNT_ZERO);
    slot2_kill     = if_valid & uncond_branch_1;
    ret_pred_valid = `FALSE;
    ret_pred_slot  = SLOT_1;
    ret_pred_pc    = 64'd0;
    if (pred_hit_s) begin
      ret_pred_valid = `TRUE;
      ret_pred_slot  = sel_slot_s;
      ret_pred_pc    = top_data_s;
    end else begin
      ret_pred_valid = `FALSE;
    end
  end

  // Pointer/occupancy next state; recovery overrides any same-cycle push or pop.
  always_comb begin
    tos_nxt_s = tos_r;
    cnt_nxt_s = cnt_r;
    wr_en_s   = `FALSE;
    if (recover_en) begin
      tos_nxt_s = recover_tos;
      cnt_nxt_s = recover_cnt;
    end else if (active_s) begin
      case (op_s)
        RAS_PUSH: begin
          tos_nxt_s = tos_r + TOS_ONE;
          wr_en_s   = `TRUE;
          cnt_nxt_s = (cnt_r == CNT_FULL) ? cnt_r : (cnt_r + CNT_ONE);
        end
        RAS_POP: begin
          if (cnt_r != CNT_ZERO) begin
            tos_nxt_s = tos_r - TOS_ONE;
            cnt_nxt_s = cnt_r - CNT_ONE;
          end else begin
            tos_nxt_s = tos_r;
            cnt_nxt_s = cnt_r;
          end
        end
        default: begin
          tos_nxt_s = tos_r;
          cnt_nxt_s = cnt_r;
        end
      endcase
    end else begin
      wr_en_s = `FALSE;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      tos_r <= {PTR_W{1'b0}};
      cnt_r <= CNT_ZERO;
    end else begin
      tos_r <= tos_nxt_s;
      cnt_r <= cnt_nxt_s;
    end
  end

  ras_storage #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_storage (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (wr_en_s),
    .wr_idx   (tos_r + TOS_ONE),
    .wr_data  (slot_ret_addr(pc_1, sel_slot_s)),
`ifdef RAS_TOP_REPAIR_EN
    .rep_en   (recover_en),
    .rep_idx  (recover_tos),
    .rep_data (recover_top),
`endif
    .rd_idx   (tos_r),
    .rd_data  (top_data_s)
  );

`ifdef RAS_TOP_REPAIR_EN
  assign ckpt_top = top_data_s;
`endif
  assign ckpt_tos = tos_r;
  assign ckpt_cnt = cnt_r;

  logic unused_s;
  assign unused_s = uncond_branch_2;

endmodule

// File: tb/tb_ras_ctrl.sv
// Self-checking bench for ras_ctrl: directed test-plan steps plus a randomized run against a
// circular-buffer reference model. Honours RAS_TOP_REPAIR_EN when defined.
module tb_ras_ctrl;

  localparam int DEPTH = 8;
  localparam int PTR_W = 3;

  logic             clock = 1'b0;
  logic             reset;
  logic             if_valid, if_stall;
  logic [63:0]      pc_1;
  logic             bsr_branch_1, bsr_branch_2, ret_branch_1, ret_branch_2;
  logic             uncond_branch_1, uncond_branch_2;
  logic             recover_en;
  logic [PTR_W-1:0] recover_tos;
  logic [PTR_W:0]   recover_cnt;
  logic [63:0]      recover_top;
  logic             slot2_kill, ret_pred_valid, ret_pred_slot;
  logic [63:0]      ret_pred_pc;
  logic [PTR_W-1:0] ckpt_tos;
  logic [PTR_W:0]   ckpt_cnt;
  logic [63:0]      ckpt_top;

  always #5 clock = ~clock;

  ras_ctrl #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clock           (clock),
    .reset           (reset),
    .if_valid        (if_valid),
    .if_stall        (if_stall),
    .pc_1            (pc_1),
    .bsr_branch_1    (bsr_branch_1),
    .bsr_branch_2    (bsr_branch_2),
    .ret_branch_1    (ret_branch_1),
    .ret_branch_2    (ret_branch_2),
    .uncond_branch_1 (uncond_branch_1),
    .uncond_branch_2 (uncond_branch_2),
    .recover_en      (recover_en),
    .recover_tos     (recover_tos),
    .recover_cnt     (recover_cnt),
`ifdef RAS_TOP_REPAIR_EN
    .recover_top     (recover_top),
    .ckpt_top        (ckpt_top),
`endif
    .slot2_kill      (slot2_kill),
    .ret_pred_valid  (ret_pred_valid),
    .ret_pred_slot   (ret_pred_slot),
    .ret_pred_pc     (ret_pred_pc),
    .ckpt_tos        (ckpt_tos),
    .ckpt_cnt        (ckpt_cnt)
  );

`ifndef RAS_TOP_REPAIR_EN
  assign ckpt_top = 64'd0;
`endif

  // Reference model: a circular stack of return addresses with a top index and a count.
  logic [63:0] m_stack [DEPTH];
  int          m_tos, m_cnt;
  bit          model_ready = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  // Outputs captured at the pre-edge sample point of the latest cycle.
  logic        obs_kill, obs_valid, obs_slot;
  logic [63:0] obs_pc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic st, input logic [63:0] pc,
                       input logic b1, input logic r1, input logic u1,
                       input logic b2, input logic r2, input logic u2);
    if_valid = v; if_stall = st; pc_1 = pc;
    bsr_branch_1 = b1; ret_branch_1 = r1; uncond_branch_1 = u1;
    bsr_branch_2 = b2; ret_branch_2 = r2; uncond_branch_2 = u2;
  endtask

  // One clock: check outputs against the model, take the edge, advance the model.
  task automatic cycle();
    bit          slot2, sel_bsr, sel_ret, exp_v;
    logic [63:0] exp_pc;
    #1;
    slot2   = !uncond_branch_1;
    sel_bsr = slot2 ? bsr_branch_2 : bsr_branch_1;
    sel_ret = slot2 ? ret_branch_2 : ret_branch_1;
    exp_v   = if_valid && sel_ret && !sel_bsr && (m_cnt > 0);
    exp_pc  = exp_v ? m_stack[m_tos] : 64'd0;
    obs_kill = slot2_kill; obs_valid = ret_pred_valid; obs_slot = ret_pred_slot; obs_pc = ret_pred_pc;
    if (model_ready) begin
      chk("slot2_kill", slot2_kill, {63'd0, if_valid & uncond_branch_1});
      chk("ret_pred_valid", ret_pred_valid, {63'd0, exp_v});
      chk("ret_pred_pc", ret_pred_pc, exp_pc);
      if (exp_v) chk("ret_pred_slot", ret_pred_slot, {63'd0, slot2});
      chk("ckpt_tos", ckpt_tos, 64'(m_tos));
      chk("ckpt_cnt", ckpt_cnt, 64'(m_cnt));
`ifdef RAS_TOP_REPAIR_EN
      chk("ckpt_top", ckpt_top, m_stack[m_tos]);
`endif
    end
    @(posedge clock);
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) m_stack[i] = 64'd0;
      m_tos = 0; m_cnt = 0; model_ready = 1'b1;
    end else if (recover_en) begin
      m_tos = int'(recover_tos); m_cnt = int'(recover_cnt);
`ifdef RAS_TOP_REPAIR_EN
      m_stack[m_tos] = recover_top;
`endif
    end else if (if_valid && !if_stall) begin
      if (sel_bsr) begin
        m_tos = (m_tos + 1) % DEPTH;
        m_stack[m_tos] = pc_1 + (slot2 ? 64'd8 : 64'd4);
        if (m_cnt < DEPTH) m_cnt++;
      end else if (sel_ret && m_cnt > 0) begin
        m_tos = (m_tos + DEPTH - 1) % DEPTH;
        m_cnt--;
      end
    end
    #1;
  endtask

  task automatic bundle(input logic [63:0] pc, input logic b1, input logic r1, input logic u1,
                        input logic b2, input logic r2);
    drive(1'b1, 1'b0, pc, b1, r1, u1, b2, r2, 1'b0);
    cycle();
  endtask

  task automatic do_reset();
    reset = 1'b1; recover_en = 1'b0;
    drive(1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    logic [PTR_W-1:0] rec_tos;
    logic [PTR_W:0]   rec_cnt, cnt_before;
    int kind1, kind2;

    reset = 1'b1; recover_en = 1'b0; recover_tos = '0; recover_cnt = '0; recover_top = 64'd0;
    drive(1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();
    chk("reset_tos", ckpt_tos, 64'd0);
    chk("reset_cnt", ckpt_cnt, 64'd0);
    drive(1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    chk("reset_idle_valid", obs_valid, 64'd0);

    // Push then return, both in slot 1.
    bundle(64'h1000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("push1_kill", obs_kill, 64'd1);
    chk("push1_cnt", ckpt_cnt, 64'd1);
    bundle(64'h1100, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("ret1_valid", obs_valid, 64'd1);
    chk("ret1_pc", obs_pc, 64'h1004);
    chk("ret1_slot", obs_slot, 64'd0);
    chk("ret1_cnt", ckpt_cnt, 64'd0);

    // Slot 2 push and return.
    bundle(64'h2000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("push2_kill", obs_kill, 64'd0);
    bundle(64'h2100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ret2_pc", obs_pc, 64'h2008);
    chk("ret2_slot", obs_slot, 64'd1);

    // Underflow.
    do_reset();
    bundle(64'h1200, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("uflow_valid", obs_valid, 64'd0);
    chk("uflow_pc", obs_pc, 64'd0);
    chk("uflow_cnt", ckpt_cnt, 64'd0);
    chk("uflow_tos", ckpt_tos, 64'd0);

    // Overflow: nine pushes, nine pops.
    for (int k = 1; k <= 9; k++) bundle(64'h100 * k, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("oflow_cnt", ckpt_cnt, 64'd8);
    for (int j = 0; j < 9; j++) begin
      bundle(64'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      if (j < 8) chk("oflow_pop_pc", obs_pc, 64'h904 - 64'h100 * j);
      else       chk("oflow_pop9_valid", obs_valid, 64'd0);
    end

    // Recovery drops a same-cycle push.
    do_reset();
    bundle(64'h3000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    rec_tos = ckpt_tos; rec_cnt = ckpt_cnt;
    chk("rec_ckpt_tos", rec_tos, 64'd1);
    chk("rec_ckpt_cnt", rec_cnt, 64'd1);
    bundle(64'h4000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    recover_en = 1'b1; recover_tos = rec_tos; recover_cnt = rec_cnt; recover_top = 64'h3004;
    bundle(64'h6000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    recover_en = 1'b0;
    chk("rec_tos", ckpt_tos, 64'd1);
    chk("rec_cnt", ckpt_cnt, 64'd1);
    bundle(64'h7000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("rec_ret_pc", obs_pc, 64'h3004);

`ifdef RAS_TOP_REPAIR_EN
    // Wrong-path pop+push corrupts entry 1; recovery repairs it.
    do_reset();
    bundle(64'h3000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    rec_tos = ckpt_tos; rec_cnt = ckpt_cnt;
    bundle(64'h3100, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    bundle(64'h5000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("repair_corrupt_top", ckpt_top, 64'h5004);
    recover_en = 1'b1; recover_tos = rec_tos; recover_cnt = rec_cnt; recover_top = 64'h3004;
    bundle(64'h6000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    recover_en = 1'b0;
    chk("repair_top", ckpt_top, 64'h3004);
    bundle(64'h7000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("repair_ret_pc", obs_pc, 64'h3004);
`endif

    // Stall holds state; reset beats recovery.
    bundle(64'h8000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    cnt_before = ckpt_cnt;
    drive(1'b1, 1'b1, 64'h8100, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    chk("stall_kill", obs_kill, 64'd1);
    chk("stall_cnt", ckpt_cnt, 64'(cnt_before));
    reset = 1'b1; recover_en = 1'b1; recover_tos = 3'd5; recover_cnt = 4'd3;
    cycle();
    reset = 1'b0; recover_en = 1'b0;
    chk("rst_rec_tos", ckpt_tos, 64'd0);
    chk("rst_rec_cnt", ckpt_cnt, 64'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      kind1 = $urandom_range(0, 3);
      kind2 = $urandom_range(0, 3);
      drive($urandom_range(0, 7) != 0, $urandom_range(0, 5) == 0,
            {$urandom, $urandom} & ~64'h3,
            kind1 == 1, kind1 == 2, $urandom_range(0, 1) == 1,
            kind2 == 1, kind2 == 2, $urandom_range(0, 1) == 1);
      recover_en  = $urandom_range(0, 15) == 0;
      recover_tos = PTR_W'($urandom_range(0, DEPTH - 1));
      recover_cnt = (PTR_W+1)'($urandom_range(0, DEPTH));
      recover_top = {$urandom, $urandom};
      reset       = $urandom_range(0, 99) == 0;
      cycle();
    end
    reset = 1'b0; recover_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
